// File: rtl/qdec_pkg.sv
// Shared types, Gray-sequence constants and the transition decoder for quad_decoder.
// Optional glitch filter is enabled with the QDEC_FILTER_EN macro.
package qdec_pkg;

   typedef logic [1:0] ab_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      DEC_IDLE    = 2'd0,
      DEC_UP      = 2'd1,
      DEC_DOWN    = 2'd2,
      DEC_ILLEGAL = 2'd3
   } dec_t;

   localparam ab_t AB_00 = 2'b00;
   localparam ab_t AB_10 = 2'b10;
   localparam ab_t AB_11 = 2'b11;
   localparam ab_t AB_01 = 2'b01;

   // Position of an {A,B} pair along the forward sequence 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] gray_pos(input ab_t ab);
      logic [1:0] pos;
      case (ab)
         AB_00:   pos = 2'd0;
         AB_10:   pos = 2'd1;
         AB_11:   pos = 2'd2;
         default: pos = 2'd3;
      endcase
      return pos;
   endfunction

   function automatic dec_t decode(input ab_t prev, input ab_t cur);
      logic [1:0] delta;
      dec_t       res;
      delta = gray_pos(cur) - gray_pos(prev);
      case (delta)
         2'd0:    res = DEC_IDLE;
         2'd1:    res = DEC_UP;
         2'd3:    res = DEC_DOWN;
         default: res = DEC_ILLEGAL;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder pins, count control and status of quad_decoder grouped into one bundle.
// Handshake: none; every input is sampled on each rising clk, outputs are registered.
interface quad_decoder_if #(
   parameter int WIDTH = 8
) ();
   import qdec_pkg::*;

   logic             a_in;
   logic             b_in;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             err_clr;
   logic [WIDTH-1:0] count;
   logic             step;
   logic             dir;
   logic             err;
   state_t           dbg_state;

   modport master (
      output a_in, b_in, en, load, load_value, err_clr,
      input  count, step, dir, err, dbg_state
   );

   modport slave (
      input  a_in, b_in, en, load, load_value, err_clr,
      output count, step, dir, err, dbg_state
   );

endinterface

// File: rtl/qdec_chan_sync.sv
// Two-flop synchronizer for one encoder channel, followed by a stability filter
// when QDEC_FILTER_EN is defined (level must hold FILT_LEN cycles to pass).
module qdec_chan_sync #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_level
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

`ifdef QDEC_FILTER_EN
   localparam int CW = $clog2(FILT_LEN) + 1;

   logic [CW-1:0] r_cnt;
   logic          r_filt;

   // r_cnt counts consecutive cycles the synchronized level has differed from r_filt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else if (r_s2 == r_filt) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
         r_cnt  <= '0;
         r_filt <= r_s2;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_level = r_filt;
`else
   assign o_level = r_s2;
`endif

endmodule

// File: rtl/quad_decoder.sv
// 4x quadrature decoder with loadable position counter and sticky illegal-transition flag.
// Define QDEC_FILTER_EN to insert a FILT_LEN-cycle glitch filter on each channel.
module quad_decoder
   import qdec_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int FILT_LEN = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   quad_decoder_if.slave bus
);

   // INIT waits until the reset zeros have drained out of the channel pipeline,
   // so the first sample captured into r_prev_ab is a real pin level.
`ifdef QDEC_FILTER_EN
   localparam int PRIME = 2 + FILT_LEN;
`else
   localparam int PRIME = 2;
`endif
   localparam int PW = $clog2(PRIME + 1);

   logic             w_a;
   logic             w_b;
   ab_t              w_ab;
   dec_t             w_dec;

   state_t           r_state;
   ab_t              r_prev_ab;
   logic [PW-1:0]    r_prime;
   logic [WIDTH-1:0] r_count;
   logic             r_step;
   logic             r_dir;
   logic             r_err;

   state_t           w_state_nxt;
   ab_t              w_prev_nxt;
   logic [PW-1:0]    w_prime_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_step_nxt;
   logic             w_dir_nxt;
   logic             w_err_nxt;

   qdec_chan_sync #(.FILT_LEN(FILT_LEN)) u_sync_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (bus.a_in),
      .o_level (w_a)
   );

   qdec_chan_sync #(.FILT_LEN(FILT_LEN)) u_sync_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (bus.b_in),
      .o_level (w_b)
   );

   assign w_ab  = {w_a, w_b};
   assign w_dec = decode(r_prev_ab, w_ab);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= INIT;
         r_prev_ab <= AB_00;
         r_prime   <= PW'(PRIME);
         r_count   <= '0;
         r_step    <= 1'b0;
         r_dir     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_prev_ab <= w_prev_nxt;
         r_prime   <= w_prime_nxt;
         r_count   <= w_count_nxt;
         r_step    <= w_step_nxt;
         r_dir     <= w_dir_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_prev_nxt  = r_prev_ab;
      w_prime_nxt = r_prime;
      w_count_nxt = r_count;
      w_step_nxt  = 1'b0;
      w_dir_nxt   = r_dir;
      w_err_nxt   = r_err & ~bus.err_clr;

      case (r_state)
         INIT: begin
            if (r_prime != '0) begin
               w_prime_nxt = r_prime - PW'(1);
            end else begin
               w_prev_nxt  = w_ab;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_prev_nxt = w_ab;
            // A load discards whatever transition decodes in the same cycle.
            if (bus.en && !bus.load) begin
               case (w_dec)
                  DEC_UP: begin
                     w_count_nxt = r_count + WIDTH'(1);
                     w_step_nxt  = 1'b1;
                     w_dir_nxt   = 1'b1;
                  end
                  DEC_DOWN: begin
                     w_count_nxt = r_count - WIDTH'(1);
                     w_step_nxt  = 1'b1;
                     w_dir_nxt   = 1'b0;
                  end
                  DEC_ILLEGAL: w_err_nxt = 1'b1;
                  default: ;
               endcase
            end
         end
         default: w_state_nxt = INIT;
      endcase

      if (bus.load) begin
         w_count_nxt = bus.load_value;
      end
   end

   assign bus.count     = r_count;
   assign bus.step      = r_step;
   assign bus.dir       = r_dir;
   assign bus.err       = r_err;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed plus randomized check of quad_decoder against an encoder-position model.
module tb_quad_decoder;
   import qdec_pkg::*;

   localparam int WIDTH    = 8;
   localparam int FILT_LEN = 3;
`ifdef QDEC_FILTER_EN
   localparam int LAT = 3 + FILT_LEN;
`else
   localparam int LAT = 3;
`endif

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   quad_decoder_if #(.WIDTH(WIDTH)) bus ();

   quad_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Encoder model: the quadrature position and the values a decoder must report.
   logic [1:0]       gray_tab [4];
   int               pos;
   logic [WIDTH-1:0] m_count;
   logic             m_dir;
   logic             m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ab(input int p);
      logic [1:0] ab;
      ab = gray_tab[p];
      bus.a_in = ab[1];
      bus.b_in = ab[0];
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"}, 32'(bus.count), 32'(m_count));
      check({tag, "_dir"},   32'(bus.dir),   32'(m_dir));
      check({tag, "_err"},   32'(bus.err),   32'(m_err));
   endtask

   // delta: +1 forward, -1 reverse, 0 no change, 2 both channels flip.
   task automatic move(input int delta, input string tag);
      logic exp_step;
      exp_step = 1'b0;
      pos = (pos + delta + 4) % 4;
      if (bus.en) begin
         if (delta == 1) begin
            m_count++;
            m_dir    = 1'b1;
            exp_step = 1'b1;
         end else if (delta == -1) begin
            m_count--;
            m_dir    = 1'b0;
            exp_step = 1'b1;
         end else if (delta == 2) begin
            m_err = 1'b1;
         end
      end
      set_ab(pos);
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) check({tag, "_early_step"}, 32'(bus.step), 32'(0));
         else         check({tag, "_step"},       32'(bus.step), 32'(exp_step));
      end
      check_state(tag);
      tick();
      tick();
      check({tag, "_step_one_cycle"}, 32'(bus.step), 32'(0));
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v, input string tag);
      bus.load       = 1'b1;
      bus.load_value = v;
      tick();
      bus.load = 1'b0;
      m_count  = v;
      check({tag, "_step"}, 32'(bus.step), 32'(0));
      check_state(tag);
   endtask

   task automatic clear_err(input string tag);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      m_err = 1'b0;
      check({tag, "_err"}, 32'(bus.err), 32'(0));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      gray_tab[0] = 2'b00;
      gray_tab[1] = 2'b10;
      gray_tab[2] = 2'b11;
      gray_tab[3] = 2'b01;
      m_count = '0;
      m_dir   = 1'b0;
      m_err   = 1'b0;

      // Reset with both channels high.
      rst_n          = 1'b0;
      pos            = 2;
      set_ab(pos);
      bus.en         = 1'b1;
      bus.load       = 1'b0;
      bus.load_value = '0;
      bus.err_clr    = 1'b0;
      repeat (3) tick();
      check("reset_count", 32'(bus.count), 32'(0));
      check("reset_step",  32'(bus.step),  32'(0));
      check("reset_dir",   32'(bus.dir),   32'(0));
      check("reset_err",   32'(bus.err),   32'(0));
      check("reset_state", 32'(bus.dbg_state), 32'(INIT));
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("post_reset_step",  32'(bus.step),  32'(0));
         check("post_reset_count", 32'(bus.count), 32'(0));
      end
      check("post_reset_state", 32'(bus.dbg_state), 32'(RUN));
      clear_err("post_reset");
      move(1, "first_edge");
      move(1, "to_00");

      // Eight forward edges from zero.
      do_load(8'h00, "load_zero");
      for (int i = 0; i < 8; i++) move(1, "fwd");
      check("fwd8_count", 32'(bus.count), 32'(8));

      // Reverse through zero.
      do_load(8'h01, "load_one");
      move(-1, "rev_to_0");
      move(-1, "rev_wrap");
      check("wrap_count", 32'(bus.count), 32'(8'hFF));

      // Illegal transitions and error clearing.
      move(2, "illegal");
      pos = (pos + 2) % 4;
      set_ab(pos);
      tick();
      tick();
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      check("illegal_with_clr_err",   32'(bus.err),   32'(1));
      check("illegal_with_clr_step",  32'(bus.step),  32'(0));
      check("illegal_with_clr_count", 32'(bus.count), 32'(m_count));
      tick();
      clear_err("clr_alone");

      // Load in the cycle a forward edge decodes.
      pos = (pos + 1) % 4;
      set_ab(pos);
      tick();
      tick();
      bus.load       = 1'b1;
      bus.load_value = 8'h40;
      tick();
      bus.load = 1'b0;
      m_count  = 8'h40;
      check("load_vs_step_step", 32'(bus.step), 32'(0));
      check_state("load_vs_step");
      tick();
      move(1, "after_load");
      check("after_load_count", 32'(bus.count), 32'(8'h41));

      // Enable low: tracking continues, nothing counts or flags.
      bus.en = 1'b0;
      move(1, "en0_fwd");
      move(2, "en0_illegal");
      bus.en = 1'b1;
      move(-1, "en1_resume");

`ifdef QDEC_FILTER_EN
      // A pulse shorter than FILT_LEN on one channel must vanish.
      bus.a_in = ~bus.a_in;
      tick();
      tick();
      bus.a_in = ~bus.a_in;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("glitch_step", 32'(bus.step), 32'(0));
      end
      check_state("glitch");
`endif

      // Randomized walk.
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 11);
         if (r <= 3)       move(1, "rnd_fwd");
         else if (r <= 6)  move(-1, "rnd_rev");
         else if (r == 7)  move(0, "rnd_idle");
         else if (r == 8)  move(2, "rnd_illegal");
         else if (r == 9)  bus.en = 1'($urandom_range(0, 1));
         else if (r == 10) do_load(WIDTH'($urandom_range(0, 255)), "rnd_load");
         else if (m_err)   clear_err("rnd_clr");
      end
      bus.en = 1'b1;

      // Asynchronous reset in the middle of operation.
      move(1, "pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      m_count = '0;
      m_dir   = 1'b0;
      m_err   = 1'b0;
      check("midreset_step",  32'(bus.step),      32'(0));
      check("midreset_state", 32'(bus.dbg_state), 32'(INIT));
      check_state("midreset");
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("midreset_rel_step",  32'(bus.step),  32'(0));
         check("midreset_rel_count", 32'(bus.count), 32'(0));
      end
      clear_err("midreset_rel");
      move(1, "midreset_fwd");
      move(-1, "midreset_rev");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature (A/B) decoder that produces the up/down/enable stimulus that drives a loadable position counter, and keeps that counter internally.
- Sits between external encoder pins and control logic.
- Decodes 4x: one count per Gray-code edge.
- Flags illegal double transitions.

Parameters:
- WIDTH, 8, width of the position count and load value.
- FILT_LEN, 3, cycles of input stability required by the glitch filter (used only when QDEC_FILTER_EN is defined; minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_in  input  1  encoder channel A; asynchronous to clk.
- b_in  input  1  encoder channel B; asynchronous to clk.
- en  input  1  count enable.
- load  input  1  synchronous load of count.
- load_value  input  WIDTH  value written on load.
- count  output  WIDTH  current position.
- step  output  1  one-cycle pulse on each accepted count change.
- dir  output  1  direction of the last accepted step (1 = up).
- err  output  1  sticky illegal-transition flag.
- err_clr  input  1  clears err.

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values: count=0, step=0, dir=0, err=0, synchronizer flops=0, FSM=INIT.
- Synchronization:
  - a_in and b_in each pass through a 2-flop synchronizer.
  - ab = {a_sync, b_sync}.
  - prev_ab register holds the last accepted state.
- FSM states: INIT, RUN.
  - INIT: prev_ab <= ab; no count, step or err; go to RUN next cycle. Prevents a spurious count after reset.
  - RUN: compare ab with prev_ab every cycle; prev_ab <= ab every cycle.
- Decode in RUN, sequence {A,B} = 00 -> 10 -> 11 -> 01 -> 00:
  - Forward step (A leads B): up.
  - Reverse step: down.
  - No change: idle.
  - Both bits changed: illegal. Sets err; no count; step=0.
- Latency: an edge on a_in or b_in reaches count/step/dir on the 3rd rising clk edge after setup (2 sync + 1 decode register).
- en=0:
  - prev_ab still tracks ab.
  - No count change, no step, no err set.
- Priority: load > decoded step.
  - load=1: count <= load_value regardless of en; step=0 that cycle; the decoded transition is discarded, but prev_ab still updates.
- Arithmetic: count is modulo 2^WIDTH. Up from all-ones wraps to 0; down from 0 wraps to all-ones.
- dir updates only when step=1, otherwise holds.
- err:
  - Set on an illegal transition while en=1 in RUN.
  - Cleared by err_clr.
  - A set event in the same cycle as err_clr wins (err stays 1).
- Reset mid-operation: async clear of all state; returns to INIT; the first post-reset ab is absorbed without counting.

Optional Feature:
- Macro: QDEC_FILTER_EN.
- Defined:
  - Each synchronized channel feeds a glitch filter; the filtered output changes only after the new level has been stable FILT_LEN consecutive cycles.
  - Latency becomes 3+FILT_LEN cycles.
  - Filter outputs reset to 0.
  - Pulses shorter than FILT_LEN cycles are ignored entirely.
- Undefined: no filter; FILT_LEN unused; latency 3.

Decomposition:
- Package qdec_pkg:
  - typedef ab_t (logic [1:0]).
  - enum state_t {INIT, RUN}.
  - Gray-sequence constants AB_00, AB_10, AB_11, AB_01.
  - Function decoding (prev, cur) to {IDLE, UP, DOWN, ILLEGAL}.
- Sub-module qdec_chan_sync: 2-flop synchronizer plus optional filter. One instance per channel, parameterized by FILT_LEN.

Test Plan:
- Reset release with a_in=1, b_in=1 held, en=1 -> count stays 0 and step never pulses; first legal edge thereafter counts.
- en=1, drive 8 forward edges (00,10,11,01,00,10,11,01,00) spaced 5 cycles -> count=8, 8 step pulses, dir=1; each step 3 cycles after its edge.
- load_value=0x01, pulse load, then 2 reverse edges -> count 0x01, 0x00, 0xFF; dir=0; wrap-around verified.
- Toggle a_in and b_in in the same cycle (00->11) -> err=1, count unchanged, step=0; err_clr together with another illegal edge -> err stays 1; err_clr alone -> err=0.
- load asserted the same cycle a forward edge decodes, load_value=0x40 -> count=0x40, step=0; the next forward edge gives 0x41.
- QDEC_FILTER_EN, FILT_LEN=3: a 2-cycle pulse on a_in -> no change; a 4-cycle-stable edge -> count increments 6 cycles after the edge.
